// File: rtl/ahim_config_pkg.sv
// Shared configuration for the HPS<->FPGA character path: widths and the
// character type used by both the receive and transmit sides.
package ahim_config_pkg;

  localparam int unsigned PIO_DATA_WIDTH = 64;
  localparam int unsigned CHAR_WIDTH     = 8;
  localparam int unsigned UINT8_WIDTH    = 8;

  typedef logic [CHAR_WIDTH-1:0] char_t;

  localparam char_t NULL_CHAR = '0;

endpackage

// File: rtl/ocr_tx_pkg.sv
// Types and constants for the OCR transmit unit.
package ocr_tx_pkg;

  import ahim_config_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } tx_state_t;

  localparam int unsigned ELEMS_PER_WORD = PIO_DATA_WIDTH / CHAR_WIDTH;
  localparam int unsigned HDR_LEN_LSB    = 0;
  localparam int unsigned HDR_LEN_MSB    = UINT8_WIDTH - 1;

  typedef char_t [ELEMS_PER_WORD-1:0] char_vec_t;

  // Element k sits at bits [(k+1)*CHAR_WIDTH-1 : k*CHAR_WIDTH], the same
  // LSB-first order the receive side packs with.
  function automatic char_vec_t unpack_word(input logic [PIO_DATA_WIDTH-1:0] word);
    char_vec_t v;
    v = '0;
    for (int unsigned k = 0; k < ELEMS_PER_WORD; k++) begin
      v[k] = word[k*CHAR_WIDTH +: CHAR_WIDTH];
    end
    return v;
  endfunction

endpackage

// File: rtl/ocr_tx_piso.sv
// Parallel-in/serial-out register for one payload word plus its slot counter.
// Ports:
//   clk_in, rst  clock and async active-high reset
//   clr          synchronous clear (highest priority)
//   load, din    load a new word and restart at slot 0
//   shift        advance one element (LSB-first)
//   elem         current element (low bits of the shift register)
//   slot_last    current slot is the last one in the word
module ocr_tx_piso #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned ELEM_W = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic [ELEM_W-1:0] elem,
  output logic              slot_last
);

  localparam int unsigned ELEMS  = WORD_W / ELEM_W;
  localparam int unsigned SLOT_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  logic [WORD_W-1:0] shreg_q;
  logic [SLOT_W-1:0] slot_q;

  // Shift register and slot counter; clear beats load beats shift.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      slot_q  <= '0;
    end else if (clr) begin
      shreg_q <= '0;
      slot_q  <= '0;
    end else if (load) begin
      shreg_q <= din;
      slot_q  <= '0;
    end else if (shift) begin
      shreg_q <= shreg_q >> ELEM_W;
      slot_q  <= slot_q + SLOT_W'(1);
    end
  end

  assign elem      = shreg_q[ELEM_W-1:0];
  assign slot_last = (slot_q == SLOT_W'(ELEMS - 1));

endmodule

// File: rtl/ocr_tx_unit.sv
// OCR transmit unit: pops length-prefixed frames from the HPS->FPGA show-ahead
// FIFO and streams the packed characters out one element per handshake.
// Ports:
//   clk_in, rst             clock and async active-high reset
//   Clear_buff              synchronous clear, abandons the current frame
//   fifo_data, fifo_empty   head word / empty flag of the FIFO
//   pop_fifo                consume head word (combinational)
//   elem_data/valid/last    element stream, elem_ready from consumer
//   OCR_TX_done             one-cycle pulse after a frame's last handshake
//   Sent_LC                 completed-frame counter (wraps)
//   hdr_zero                sticky: a zero-length header was seen
//   busy                    FSM is not idle
module ocr_tx_unit
  import ahim_config_pkg::*;
  import ocr_tx_pkg::*;
#(
  parameter int unsigned WORD_W = PIO_DATA_WIDTH,
  parameter int unsigned ELEM_W = CHAR_WIDTH,
  parameter int unsigned LEN_W  = UINT8_WIDTH
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              Clear_buff,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              pop_fifo,
  output logic [ELEM_W-1:0] elem_data,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic              elem_last,
  output logic              OCR_TX_done,
  output logic [LEN_W-1:0]  Sent_LC,
  output logic              hdr_zero,
  output logic              busy
);

  tx_state_t        state_q, state_n;
  logic [LEN_W-1:0] rem_q, rem_n;
  logic [LEN_W-1:0] sent_q, sent_n;
  logic             hz_q, hz_n;
  logic             done_q, done_n;
  logic             valid_q, valid_n;
  logic             last_q, last_n;
  logic             busy_q;
  logic             pop_c;
  logic             piso_load, piso_shift;
  logic             slot_last;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_len = fifo_data[HDR_LEN_LSB +: LEN_W];

  ocr_tx_piso #(
    .WORD_W (WORD_W),
    .ELEM_W (ELEM_W)
  ) u_piso (
    .clk_in    (clk_in),
    .rst       (rst),
    .clr       (Clear_buff),
    .load      (piso_load),
    .shift     (piso_shift),
    .din       (fifo_data),
    .elem      (elem_data),
    .slot_last (slot_last)
  );

  // State and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sent_q  <= '0;
      hz_q    <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      sent_q  <= sent_n;
      hz_q    <= hz_n;
      done_q  <= done_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  // Next state; valid/last are precomputed so they leave straight from flops.
  always_comb begin
    state_n    = state_q;
    rem_n      = rem_q;
    sent_n     = sent_q;
    hz_n       = hz_q;
    done_n     = 1'b0;
    valid_n    = 1'b0;
    last_n     = 1'b0;
    pop_c      = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    if (Clear_buff) begin
      state_n = IDLE;
      rem_n   = '0;
      sent_n  = '0;
      hz_n    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop_c = 1'b1;
            rem_n = hdr_len;
            if (hdr_len == '0) begin
              hz_n = 1'b1;
            end else begin
              state_n = FETCH;
            end
          end
        end
        FETCH: begin
          if (!fifo_empty) begin
            pop_c     = 1'b1;
            piso_load = 1'b1;
            state_n   = SEND;
            valid_n   = 1'b1;
            last_n    = (rem_q == LEN_W'(1));
          end
        end
        SEND: begin
          valid_n = 1'b1;
          last_n  = last_q;
          if (elem_ready) begin
            piso_shift = 1'b1;
            rem_n      = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
              sent_n  = sent_q + LEN_W'(1);
              valid_n = 1'b0;
              last_n  = 1'b0;
            end else if (slot_last) begin
              // Word exhausted: one bubble cycle to fetch the next one.
              state_n = FETCH;
              valid_n = 1'b0;
              last_n  = 1'b0;
            end else begin
              last_n = (rem_q == LEN_W'(2));
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign pop_fifo    = pop_c;
  assign elem_valid  = valid_q;
  assign elem_last   = last_q;
  assign OCR_TX_done = done_q;
  assign Sent_LC     = sent_q;
  assign hdr_zero    = hz_q;
  assign busy        = busy_q;

endmodule
